instruction_id_tracker: RTL and testbench
=========================================

# instruction_id_tracker

Parametrised successor to the toggle-memory ID manager: tracks every in-flight instruction ID through an explicit per-ID lifecycle (FREE → ALLOCATED → ISSUED → COMPLETE → FREE). It has N completion ports, in-order multi-wide retirement, fetch-flush rollback, and M operand-readiness query ports. It sits between fetch/decode (allocation), issue, the execution units (completion) and writeback/commit (retire).

## Interface
- NUM_IDS, 8: ID pool size; power of two, ≥4; IDX_W = $clog2(NUM_IDS).
- NUM_COMPLETE_PORTS, 4: independent completion sources.
- RETIRE_WIDTH, 2: maximum IDs retired per cycle; 1..NUM_IDS.
- NUM_QUERY_PORTS, 2: operand status query ports.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  consume alloc_id this cycle; legal only when alloc_ready=1.
- alloc_ready  out  IDX_W-free  1 when inflight_count < NUM_IDS.
- alloc_id  out  IDX_W  next ID to allocate.
- issue_valid  in  1  issue the oldest ALLOCATED ID.
- issue_id  out  IDX_W  oldest ALLOCATED ID.
- issue_id_valid  out  1  an ALLOCATED ID exists.
- complete_valid  in  [NUM_COMPLETE_PORTS]  completion strobes.
- complete_id  in  [NUM_COMPLETE_PORTS][IDX_W]  completing IDs.
- flush  in  1  discard every ALLOCATED (unissued) ID.
- retire_valid  out  1  registered; retirement occurred.
- retire_base_id  out  IDX_W  registered; oldest retired ID.
- retire_count  out  $clog2(RETIRE_WIDTH+1)  registered; 1..RETIRE_WIDTH when valid, else 0.
- query_id  in  [NUM_QUERY_PORTS][IDX_W]  IDs to check.
- query_pending  out  [NUM_QUERY_PORTS]  combinational; 1 if the ID is ISSUED (not yet COMPLETE).
- inflight_count  out  IDX_W+1  IDs not FREE.

## Operation
- State: status[NUM_IDS] (2-bit enum); head_ptr (oldest non-FREE); issue_ptr; alloc_ptr; count (IDX_W+1 bits). All pointers are IDX_W bits and wrap modulo NUM_IDS. count disambiguates full (NUM_IDS) from empty (0) when pointers are equal.
- Allocate: alloc_req sets status[alloc_ptr]=ALLOCATED, alloc_ptr+1, count+1.
- Issue: issue_valid with issue_id_valid=1 sets status[issue_ptr]=ISSUED, issue_ptr+1. issue_valid with issue_id_valid=0 is ignored.
- Complete: each valid port sets its ID to COMPLETE only if the ID is currently ISSUED; otherwise the strobe is ignored. Duplicate IDs across ports in the same cycle are idempotent.
- Retire: scan from head_ptr. k = number of consecutive COMPLETE entries, capped at RETIRE_WIDTH and count. If k>0, those IDs become FREE, head_ptr+k, count-k, and the registered outputs carry base=head_ptr and count=k.
- Flush: every ALLOCATED entry becomes FREE; alloc_ptr ← issue_ptr; count ← count minus the number of ALLOCATED entries (alloc_ptr−issue_ptr).
- Simultaneous events in one cycle are all applied. Net count = count + alloc − k − flushed.
  - flush+alloc_req: the allocation is discarded.
  - flush+issue_valid: the issue takes effect, and alloc_ptr ← issue_ptr+1.
  - Completion and retire of different IDs are independent. A completion sampled this cycle is not retired this cycle.
- Assertions (simulation): alloc_req while !alloc_ready; complete on a non-ISSUED ID; count > NUM_IDS.

## Timing
- Reset values: all status FREE; pointers 0; count 0; alloc_ready=1; alloc_id=0; issue_id_valid=0; issue_id=0; retire_valid=0; retire_count=0; retire_base_id=0; query_pending=0; inflight_count=0.
- Reset asserted mid-operation clears everything immediately; nothing is retired.
- alloc_ready, issue_id_valid and query_pending are combinational from current state. A slot freed by retire at edge N is allocatable in cycle N+1.
- Completion latency: complete_valid in cycle N → status COMPLETE in N+1 → query_pending=0 in N+1 → retire decision in N+1 → retire_valid high in N+2.
- Alloc→issue: an ID allocated in cycle N is issueable in N+1.

## Configuration
- ID_TRACKER_STATS_EN defined: adds outputs stat_retired (32-bit, accumulates retire_count) and stat_alloc_stall (32-bit, cycles with alloc_req=0 and alloc_ready=0 while flush=0). Both reset to 0 and wrap silently.
- ID_TRACKER_STATS_EN undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared types package: id_status_t enum (FREE=0, ALLOCATED=1, ISSUED=2, COMPLETE=3) and the IDX_W/count-width derivation functions.
- Sub-module id_retire_scan: a combinational scan of status from head_ptr with wrap. It outputs k (0..RETIRE_WIDTH) and is parametrised by NUM_IDS and RETIRE_WIDTH.

## Test plan
- Reset, then 8 alloc_req cycles (NUM_IDS=8) → alloc_id 0..7, alloc_ready=0 after the 8th, inflight_count=8.
- Alloc 3, issue 3, complete IDs 0 and 1 on ports 0 and 3 in cycle N → retire_valid in N+2 with base=0, count=2; ID 2 stays pending (query_pending=1).
- Complete ID 1 only, then ID 0 later → no retire until ID 0 completes; then base=0, count=2 (in-order).
- Alloc 5, issue 2, flush with issue_valid → alloc_ptr=3, inflight_count=3, next alloc_id=3.
- Wrap: cycle 20 IDs through with RETIRE_WIDTH=2 and 4 completes per cycle → retire_count never exceeds 2, base IDs wrap 7→0, count returns to 0.
- Complete on an ALLOCATED ID → ignored, status unchanged, assertion fires.

Source files
------------

// File: rtl/instruction_id_tracker_pkg.sv
// Shared types and width helpers for the instruction ID tracker.
package instruction_id_tracker_pkg;

    // Per-ID lifecycle: FREE -> ALLOCATED -> ISSUED -> COMPLETE -> FREE
    typedef enum logic [1:0] {
        IdFree      = 2'd0,
        IdAllocated = 2'd1,
        IdIssued    = 2'd2,
        IdComplete  = 2'd3
    } id_status_t;

    // Index width for a pool of n IDs (at least one bit)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/instruction_id_tracker_retire_scan.sv
// id_retire_scan: counts consecutive COMPLETE entries from the head pointer (with wrap),
// capped at RETIRE_WIDTH and at the number of in-flight IDs.
module id_retire_scan
    import instruction_id_tracker_pkg::*;
#(
    parameter int unsigned NUM_IDS      = 8,
    parameter int unsigned RETIRE_WIDTH = 2,
    localparam int unsigned IDX_W = idx_w(NUM_IDS),
    localparam int unsigned CNT_W = IDX_W + 1,
    localparam int unsigned K_W   = cnt_w(RETIRE_WIDTH)
) (
    input  id_status_t [NUM_IDS-1:0] i_status,
    input  logic [IDX_W-1:0]         i_head,
    input  logic [CNT_W-1:0]         i_count,
    output logic [K_W-1:0]           o_k
);

    logic             w_run;
    logic [IDX_W-1:0] w_idx;

    // Stop at the first entry that is not COMPLETE so retirement stays in order
    always_comb begin
        o_k   = '0;
        w_run = 1'b1;
        w_idx = '0;
        for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
            w_idx = i_head + IDX_W'(i);
            if (w_run && (CNT_W'(i) < i_count) && (i_status[w_idx] == IdComplete)) begin
                o_k = o_k + K_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_id_tracker.sv
// instruction_id_tracker: per-ID lifecycle tracking with multi-port completion, in-order
// multi-wide retirement, flush rollback and operand-readiness queries.
// Optional feature macro: ID_TRACKER_STATS_EN adds o_stat_retired / o_stat_alloc_stall.
module instruction_id_tracker
    import instruction_id_tracker_pkg::*;
#(
    parameter int unsigned NUM_IDS            = 8,
    parameter int unsigned NUM_COMPLETE_PORTS = 4,
    parameter int unsigned RETIRE_WIDTH       = 2,
    parameter int unsigned NUM_QUERY_PORTS    = 2,
    localparam int unsigned IDX_W  = idx_w(NUM_IDS),
    localparam int unsigned CNT_W  = IDX_W + 1,
    localparam int unsigned RCNT_W = cnt_w(RETIRE_WIDTH)
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic                                     i_alloc_req,
    output logic                                     o_alloc_ready,
    output logic [IDX_W-1:0]                         o_alloc_id,
    input  logic                                     i_issue_valid,
    output logic [IDX_W-1:0]                         o_issue_id,
    output logic                                     o_issue_id_valid,
    input  logic [NUM_COMPLETE_PORTS-1:0]            i_complete_valid,
    input  logic [NUM_COMPLETE_PORTS-1:0][IDX_W-1:0] i_complete_id,
    input  logic                                     i_flush,
    output logic                                     o_retire_valid,
    output logic [IDX_W-1:0]                         o_retire_base_id,
    output logic [RCNT_W-1:0]                        o_retire_count,
    input  logic [NUM_QUERY_PORTS-1:0][IDX_W-1:0]    i_query_id,
    output logic [NUM_QUERY_PORTS-1:0]               o_query_pending,
`ifdef ID_TRACKER_STATS_EN
    output logic [31:0]                              o_stat_retired,
    output logic [31:0]                              o_stat_alloc_stall,
`endif
    output logic [CNT_W-1:0]                         o_inflight_count
);

    id_status_t [NUM_IDS-1:0] r_status;
    id_status_t [NUM_IDS-1:0] w_status_d;
    logic [IDX_W-1:0]         r_head, r_issue, r_alloc;
    logic [IDX_W-1:0]         w_head_d, w_issue_d, w_alloc_d;
    logic [CNT_W-1:0]         r_count, w_count_d;
    logic                     r_retire_valid;
    logic [IDX_W-1:0]         r_retire_base;
    logic [RCNT_W-1:0]        r_retire_count;
    logic [RCNT_W-1:0]        w_k;
    logic                     w_do_alloc, w_do_issue;
    logic [CNT_W-1:0]         w_n_alloc, w_flushed;

    id_retire_scan #(
        .NUM_IDS      (NUM_IDS),
        .RETIRE_WIDTH (RETIRE_WIDTH)
    ) u_retire_scan (
        .i_status (r_status),
        .i_head   (r_head),
        .i_count  (r_count),
        .o_k      (w_k)
    );

    assign o_alloc_ready    = (r_count < CNT_W'(NUM_IDS));
    assign o_alloc_id       = r_alloc;
    assign o_issue_id       = r_issue;
    assign o_issue_id_valid = (r_status[r_issue] == IdAllocated);
    assign o_inflight_count = r_count;
    assign o_retire_valid   = r_retire_valid;
    assign o_retire_base_id = r_retire_base;
    assign o_retire_count   = r_retire_count;

    // A flush cancels any allocation in the same cycle
    assign w_do_alloc = i_alloc_req && o_alloc_ready && !i_flush;
    assign w_do_issue = i_issue_valid && o_issue_id_valid;

    // Query ports report IDs still waiting for their result
    always_comb begin
        o_query_pending = '0;
        for (int unsigned q = 0; q < NUM_QUERY_PORTS; q++) begin
            o_query_pending[q] = (r_status[i_query_id[q]] == IdIssued);
        end
    end

    // Count ALLOCATED entries directly; pointer difference is ambiguous when the pool is full
    always_comb begin
        w_n_alloc = '0;
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (r_status[i] == IdAllocated) w_n_alloc = w_n_alloc + CNT_W'(1);
        end
    end

    // An entry issued during a flush survives it
    assign w_flushed = i_flush ? (w_n_alloc - CNT_W'(w_do_issue)) : '0;

    // Next-state status: complete, retire, flush, issue, allocate
    always_comb begin
        w_status_d = r_status;
        for (int unsigned p = 0; p < NUM_COMPLETE_PORTS; p++) begin
            if (i_complete_valid[p] && (r_status[i_complete_id[p]] == IdIssued)) begin
                w_status_d[i_complete_id[p]] = IdComplete;
            end
        end
        for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
            if (RCNT_W'(i) < w_k) w_status_d[r_head + IDX_W'(i)] = IdFree;
        end
        if (i_flush) begin
            for (int unsigned i = 0; i < NUM_IDS; i++) begin
                if (r_status[i] == IdAllocated) w_status_d[i] = IdFree;
            end
        end
        if (w_do_issue) w_status_d[r_issue] = IdIssued;
        if (w_do_alloc) w_status_d[r_alloc] = IdAllocated;
    end

    // Next-state pointers and occupancy
    always_comb begin
        w_head_d  = r_head + IDX_W'(w_k);
        w_issue_d = r_issue + IDX_W'(w_do_issue);
        w_alloc_d = i_flush ? (r_issue + IDX_W'(w_do_issue)) : (r_alloc + IDX_W'(w_do_alloc));
        w_count_d = r_count + CNT_W'(w_do_alloc) - CNT_W'(w_k) - w_flushed;
    end

    // State and registered retire outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_status       <= {NUM_IDS{IdFree}};
            r_head         <= '0;
            r_issue        <= '0;
            r_alloc        <= '0;
            r_count        <= '0;
            r_retire_valid <= 1'b0;
            r_retire_base  <= '0;
            r_retire_count <= '0;
        end else begin
            r_status       <= w_status_d;
            r_head         <= w_head_d;
            r_issue        <= w_issue_d;
            r_alloc        <= w_alloc_d;
            r_count        <= w_count_d;
            r_retire_valid <= (w_k != '0);
            r_retire_base  <= r_head;
            r_retire_count <= w_k;
        end
    end

`ifdef ID_TRACKER_STATS_EN
    logic [31:0] r_stat_retired, r_stat_alloc_stall;

    // Free-running statistics, wrapping silently
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_retired     <= '0;
            r_stat_alloc_stall <= '0;
        end else begin
            r_stat_retired <= r_stat_retired + 32'(w_k);
            if (!i_alloc_req && !o_alloc_ready && !i_flush) begin
                r_stat_alloc_stall <= r_stat_alloc_stall + 32'd1;
            end
        end
    end

    assign o_stat_retired     = r_stat_retired;
    assign o_stat_alloc_stall = r_stat_alloc_stall;
`endif

`ifndef SYNTHESIS
    a_alloc_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_alloc_req |-> o_alloc_ready)
        else $error("alloc_req while alloc_ready is low");

    a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_count <= CNT_W'(NUM_IDS))
        else $error("inflight count exceeds pool size");

    // Stray completions are dropped by the logic; flag them without stopping simulation
    for (genvar p = 0; p < NUM_COMPLETE_PORTS; p++) begin : g_cmp_chk
        a_cmp_issued: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            i_complete_valid[p] |-> (r_status[i_complete_id[p]] == IdIssued))
            else $warning("completion on port %0d for non-issued id %0d ignored",
                          p, i_complete_id[p]);
    end
`endif

endmodule

// File: tb/tb_instruction_id_tracker.sv
// Self-checking bench for instruction_id_tracker (NUM_IDS=8, 4 completion ports,
// RETIRE_WIDTH=2, 2 query ports). Expected retirements go into a scoreboard queue that a
// negedge monitor drains whenever retire_valid is high.
module tb_instruction_id_tracker;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 alloc_req = 1'b0;
    logic                 issue_valid = 1'b0;
    logic                 flush = 1'b0;
    logic [3:0]           cv = '0;
    logic [3:0][2:0]      cid = '0;
    logic [1:0][2:0]      qid = '0;
    logic                 alloc_ready, issue_id_valid, retire_valid;
    logic [2:0]           alloc_id, issue_id, retire_base;
    logic [1:0]           retire_count;
    logic [1:0]           query_pending;
    logic [3:0]           inflight;
`ifdef ID_TRACKER_STATS_EN
    logic [31:0]          stat_retired, stat_alloc_stall;
`endif

    typedef struct packed {
        logic [2:0] base;
        logic [1:0] cnt;
    } ret_t;

    ret_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    instruction_id_tracker #(
        .NUM_IDS            (8),
        .NUM_COMPLETE_PORTS (4),
        .RETIRE_WIDTH       (2),
        .NUM_QUERY_PORTS    (2)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_alloc_req        (alloc_req),
        .o_alloc_ready      (alloc_ready),
        .o_alloc_id         (alloc_id),
        .i_issue_valid      (issue_valid),
        .o_issue_id         (issue_id),
        .o_issue_id_valid   (issue_id_valid),
        .i_complete_valid   (cv),
        .i_complete_id      (cid),
        .i_flush            (flush),
        .o_retire_valid     (retire_valid),
        .o_retire_base_id   (retire_base),
        .o_retire_count     (retire_count),
        .i_query_id         (qid),
        .o_query_pending    (query_pending),
`ifdef ID_TRACKER_STATS_EN
        .o_stat_retired     (stat_retired),
        .o_stat_alloc_stall (stat_alloc_stall),
`endif
        .o_inflight_count   (inflight)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ret(input int b, input int c);
        ret_t e;
        e.base = 3'(b);
        e.cnt  = 2'(c);
        exp_q.push_back(e);
    endtask

    // Advance one clock; pulse-type inputs return low afterwards
    task automatic cyc();
        @(posedge clk);
        #1;
        alloc_req   = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
        cv          = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_req = 1'b0; issue_valid = 1'b0; flush = 1'b0; cv = '0;
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retirement must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (rst_n && retire_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_retire: got base %0d count %0d, expected none",
                         retire_base, retire_count);
            end else begin
                ret_t e;
                e = exp_q.pop_front();
                chk("retire_base", int'(retire_base), int'(e.base));
                chk("retire_count", int'(retire_count), int'(e.cnt));
            end
        end
    end

    initial begin
        int s;
        do_reset();

        // Reset values
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_issue_id_valid", issue_id_valid, 0);
        chk("rst_issue_id", issue_id, 0);
        chk("rst_retire_valid", retire_valid, 0);
        chk("rst_retire_count", retire_count, 0);
        chk("rst_retire_base", retire_base, 0);
        chk("rst_query_pending", query_pending, 0);
        chk("rst_inflight", inflight, 0);

        // Fill the pool
        for (int i = 0; i < 8; i++) begin
            chk("fill_alloc_id", alloc_id, i);
            chk("fill_alloc_ready", alloc_ready, 1);
            alloc_req = 1'b1;
            cyc();
        end
        chk("full_alloc_ready", alloc_ready, 0);
        chk("full_inflight", inflight, 8);

        // Asynchronous reset mid-operation clears immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_inflight", inflight, 0);
        chk("async_rst_alloc_ready", alloc_ready, 1);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Alloc 3, issue 3, complete 0 and 1 together
        for (int i = 0; i < 3; i++) begin alloc_req = 1'b1; cyc(); end
        for (int i = 0; i < 3; i++) begin
            chk("issue_id", issue_id, i);
            chk("issue_id_valid", issue_id_valid, 1);
            issue_valid = 1'b1;
            cyc();
        end
        chk("issued_none_left", issue_id_valid, 0);
        cv = 4'b1001; cid[0] = 3'd0; cid[3] = 3'd1;
        expect_ret(0, 2);
        cyc();
        qid[0] = 3'd2; qid[1] = 3'd0;
        #1;
        chk("lat_n1_retire_valid", retire_valid, 0);
        chk("q_id2_pending", query_pending[0], 1);
        chk("q_id0_done", query_pending[1], 0);
        cyc();
        chk("lat_n2_retire_valid", retire_valid, 1);
        // Duplicate completion of ID 2 on two ports
        cv = 4'b0110; cid[1] = 3'd2; cid[2] = 3'd2;
        expect_ret(2, 1);
        cyc(); cyc(); cyc();
        chk("t3_inflight", inflight, 0);

        // Out-of-order completion: ID 4 first, ID 3 later
        alloc_req = 1'b1; cyc();
        alloc_req = 1'b1; cyc();
        issue_valid = 1'b1; cyc();
        issue_valid = 1'b1; cyc();
        cv = 4'b0010; cid[1] = 3'd4;
        cyc();
        qid[0] = 3'd4; qid[1] = 3'd3;
        #1;
        chk("ooo_q4", query_pending[0], 0);
        chk("ooo_q3", query_pending[1], 1);
        cyc(); cyc(); cyc();
        chk("ooo_no_retire", retire_valid, 0);
        chk("ooo_inflight", inflight, 2);
        cv = 4'b0001; cid[0] = 3'd3;
        expect_ret(3, 2);
        cyc(); cyc(); cyc();
        chk("ooo_inflight_end", inflight, 0);

        // Flush with concurrent issue (and a discarded allocation)
        do_reset();
        for (int i = 0; i < 5; i++) begin alloc_req = 1'b1; cyc(); end
        issue_valid = 1'b1; cyc();
        issue_valid = 1'b1; cyc();
        flush = 1'b1; issue_valid = 1'b1; alloc_req = 1'b1;
        cyc();
        chk("flush_alloc_id", alloc_id, 3);
        chk("flush_inflight", inflight, 3);
        chk("flush_issue_id_valid", issue_id_valid, 0);
        chk("flush_issue_id", issue_id, 3);
        cv = 4'b0111; cid[0] = 3'd0; cid[1] = 3'd1; cid[2] = 3'd2;
        expect_ret(0, 2);
        expect_ret(2, 1);
        cyc(); cyc(); cyc(); cyc();
        chk("flush_inflight_end", inflight, 0);

        // Completion on an ALLOCATED ID is ignored
        alloc_req = 1'b1; cyc();
        cv = 4'b0100; cid[2] = 3'd3;
        cyc(); cyc();
        qid[0] = 3'd3;
        #1;
        chk("bad_cmp_still_alloc", issue_id_valid, 1);
        chk("bad_cmp_issue_id", issue_id, 3);
        chk("bad_cmp_not_pending", query_pending[0], 0);
        chk("bad_cmp_inflight", inflight, 1);
        issue_valid = 1'b1; cyc();
        chk("bad_cmp_now_pending", query_pending[0], 1);
        cv = 4'b0001; cid[0] = 3'd3;
        expect_ret(3, 1);
        cyc(); cyc(); cyc();
        chk("bad_cmp_inflight_end", inflight, 0);

        // Wrap: offset by one, then five groups of four completed at once
        do_reset();
        alloc_req = 1'b1; cyc();
        issue_valid = 1'b1; cyc();
        cv = 4'b0001; cid[0] = 3'd0;
        expect_ret(0, 1);
        cyc(); cyc(); cyc();
        for (int c = 0; c < 5; c++) begin
            s = (1 + 4 * c) % 8;
            for (int i = 0; i < 4; i++) begin alloc_req = 1'b1; cyc(); end
            for (int i = 0; i < 4; i++) begin issue_valid = 1'b1; cyc(); end
            cv = 4'hF;
            for (int p = 0; p < 4; p++) cid[p] = 3'((s + p) % 8);
            expect_ret(s, 2);
            expect_ret((s + 2) % 8, 2);
            cyc(); cyc(); cyc(); cyc();
            chk("wrap_drain", inflight, 0);
        end
        chk("wrap_alloc_id", alloc_id, 5);

        // Bounded wait for any outstanding expectations
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
